// File: rtl/led_display_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_display_arbiter_if                                                   |
// | Requester-side bus of the shared 7-segment display arbiter.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface led_display_arbiter_if #(
   parameter int NUM = 4,
   parameter int REQ = 3
);
   localparam int c_DIG_W = (NUM > 1) ? $clog2(NUM) : 1;
   localparam int c_OW    = (REQ > 1) ? $clog2(REQ) : 1;

   logic [REQ-1:0]         req;
   logic [REQ-1:0]         wr_valid;
   logic [REQ*c_DIG_W-1:0] wr_digit;
   logic [REQ*8-1:0]       wr_data;
   logic [REQ-1:0]         wr_ready;
   logic [REQ-1:0]         grant;
   logic [c_OW-1:0]        owner_id;
   logic                   busy;
   logic [NUM*8-1:0]       led_out;

   modport master (
      output req, wr_valid, wr_digit, wr_data,
      input  wr_ready, grant, owner_id, busy, led_out
   );

   modport slave (
      input  req, wr_valid, wr_digit, wr_data,
      output wr_ready, grant, owner_id, busy, led_out
   );
endinterface
`default_nettype wire

// File: rtl/led_display_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_display_arbiter                                                      |
// | Round-robin owner arbitration of one NUM-digit 7-seg display with dwell  |
// | preemption and blank handover gap. Optional macro                        |
// | LED_DISPLAY_ARB_SHADOW_EN keeps one digit buffer per requester.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module led_display_arbiter #(
   parameter int NUM          = 4,
   parameter int REQ          = 3,
   parameter int MAX_HOLD     = 0,
   parameter int BLANK_CYCLES = 1
) (
   input logic                  clk,
   input logic                  rstn,
   led_display_arbiter_if.slave bus
);
   localparam int c_DIG_W  = (NUM > 1) ? $clog2(NUM) : 1;
   localparam int c_OW     = (REQ > 1) ? $clog2(REQ) : 1;
   localparam int c_HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int c_BLK_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_OWNED  = 2'd1,
      S_SWITCH = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_OW-1:0]      r_owner;
   logic [c_OW-1:0]      r_ptr;
   logic [c_HOLD_W-1:0]  r_hold;
   logic [c_BLK_W-1:0]   r_blank;

   logic [REQ-1:0]       w_onehot;
   logic [c_OW-1:0]      w_pick;
   logic                 w_release;
   logic                 w_handover;
   logic                 w_wr_en;
   logic [c_DIG_W-1:0]   w_dig_arr  [REQ];
   logic [7:0]           w_data_arr [REQ];
   logic [c_DIG_W-1:0]   w_own_dig;
   logic [7:0]           w_own_data;
   logic [7:0]           w_view [NUM];

   // First requester at or after ptr, wrapping REQ-1 -> 0.
   function automatic logic [c_OW-1:0] rr_pick(input logic [REQ-1:0] r,
                                               input logic [c_OW-1:0] ptr);
      logic [c_OW-1:0] pick;
      logic [c_OW-1:0] idx;
      logic            found;
      int              s;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < REQ; i++) begin
         s = int'(ptr) + i;
         if (s >= REQ) s = s - REQ;
         idx = c_OW'(s);
         if (!found && r[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      return pick;
   endfunction

   always_comb begin
      for (int i = 0; i < REQ; i++) begin
         w_dig_arr[i]  = bus.wr_digit[i*c_DIG_W +: c_DIG_W];
         w_data_arr[i] = bus.wr_data[i*8 +: 8];
      end
   end

   assign w_own_dig  = w_dig_arr[r_owner];
   assign w_own_data = w_data_arr[r_owner];
   assign w_onehot   = {{(REQ-1){1'b0}}, 1'b1} << r_owner;
   assign w_pick     = rr_pick(bus.req, r_ptr);
   assign w_release  = !bus.req[r_owner] ||
                       ((MAX_HOLD != 0) && (r_hold == c_HOLD_W'(MAX_HOLD)) &&
                        (|(bus.req & ~w_onehot)));
   assign w_handover = (r_state == S_OWNED) && w_release;
   // Out-of-range digit indices are handshaken but never stored.
   assign w_wr_en    = (r_state == S_OWNED) && bus.wr_valid[r_owner] &&
                       (int'(w_own_dig) < NUM);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      bus.grant    = '0;
      bus.wr_ready = '0;
      bus.busy     = 1'b0;
      bus.owner_id = r_owner;
      case (r_state)
         S_IDLE: begin
            if (|bus.req) w_state_nxt = S_OWNED;
         end
         S_OWNED: begin
            bus.grant    = w_onehot;
            bus.wr_ready = w_onehot;
            bus.busy     = 1'b1;
            if (w_release) w_state_nxt = S_SWITCH;
         end
         S_SWITCH: begin
            if (r_blank == c_BLK_W'(BLANK_CYCLES - 1)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_owner <= '0;
         r_ptr   <= '0;
         r_hold  <= '0;
         r_blank <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|bus.req) begin
                  r_owner <= w_pick;
                  r_hold  <= '0;
               end
            end
            S_OWNED: begin
               if (r_hold != c_HOLD_W'(MAX_HOLD)) r_hold <= r_hold + 1'b1;
               if (w_release) begin
                  r_ptr   <= (r_owner == c_OW'(REQ - 1)) ? '0 : r_owner + 1'b1;
                  r_blank <= '0;
               end
            end
            S_SWITCH: r_blank <= r_blank + 1'b1;
            default: ;
         endcase
      end
   end

`ifdef LED_DISPLAY_ARB_SHADOW_EN
   logic [7:0] r_shadow [REQ][NUM];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < REQ; i++)
            for (int d = 0; d < NUM; d++)
               r_shadow[i][d] <= '0;
      end else if (w_wr_en) begin
         r_shadow[r_owner][w_own_dig] <= w_own_data;
      end
   end

   always_comb begin
      for (int d = 0; d < NUM; d++) w_view[d] = r_shadow[r_owner][d];
   end
`else
   logic [7:0] r_buf [NUM];

   // Clearing on handover overrides a write accepted in the exit cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int d = 0; d < NUM; d++) r_buf[d] <= '0;
      end else begin
         if (w_wr_en) r_buf[w_own_dig] <= w_own_data;
         if (w_handover)
            for (int d = 0; d < NUM; d++) r_buf[d] <= '0;
      end
   end

   always_comb begin
      for (int d = 0; d < NUM; d++) w_view[d] = r_buf[d];
   end
`endif

   always_comb begin
      bus.led_out = '0;
      if (r_state == S_OWNED)
         for (int d = 0; d < NUM; d++) bus.led_out[d*8 +: 8] = w_view[d];
   end
endmodule
`default_nettype wire
